// File: rtl/edge_pkg.sv
// Shared definitions for the edge event counter slice.
//   MODE_*     : encodings of i_mode (which o_q edges advance the event counter)
//   deb_width(): width of the debounce counter for a given DEB_CYCLES
package edge_pkg;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_NONE = 2'b11;

  // Counter must hold 0..DEB_CYCLES; never narrower than one bit.
  function automatic int deb_width(input int deb_cycles);
    int w;
    w = $clog2(deb_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Generic multi-flop synchronizer for one asynchronous level.
// Ports:
//   i_clk  : clock, rising edge
//   i_rstn : synchronous active-low reset, clears every stage
//   i_d    : asynchronous input
//   o_q    : i_d delayed by SYNC_STAGES edges
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] stages;

  // NOTE: reset is sampled on the clock edge only; a low i_rstn between
  // edges does nothing until the next posedge.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/edge_event_counter.sv
// Conditions one asynchronous level into clean edge events and counts them:
// synchronizer -> debounce filter -> o_q -> rise/fall pulses -> event counter.
// Ports:
//   i_clk    : clock, rising edge
//   i_rstn   : synchronous active-low reset, clears every flop
//   i_d      : asynchronous level input
//   i_clr    : synchronous clear of o_cnt and o_ovf (wins over a same-edge event)
//   i_mode   : 00 count rise, 01 count fall, 10 count both, 11 count none
//   o_q      : synchronized, debounced level
//   o_rise   : one-cycle pulse in the cycle o_q goes 0->1
//   o_fall   : one-cycle pulse in the cycle o_q goes 1->0
//   o_cnt    : saturating count of selected edges
//   o_ovf    : sticky, set when a count is attempted at all-ones
module edge_event_counter
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_d,
  input  logic             i_clr,
  input  logic [1:0]       i_mode,
  output logic             o_q,
  output logic             o_rise,
  output logic             o_fall,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ovf
);

  localparam int               DEB_W    = deb_width(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync_out;
  logic [DEB_W-1:0] deb;
  logic             flip;
  logic             rise_evt;
  logic             fall_evt;
  logic             count_evt;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .i_d   (sync_out_unused_guard(i_d)),
    .o_q   (sync_out)
  );

  // Pass-through kept as a function so the connection reads as a plain wire.
  function automatic logic sync_out_unused_guard(input logic d);
    return d;
  endfunction

  // The edge that will update o_q on this clock, and whether i_mode selects it.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    flip      = (sync_out != o_q) && (deb == DEB_LAST);
    rise_evt  = flip &  sync_out;
    fall_evt  = flip & ~sync_out;
    count_evt = 1'b0;
    case (i_mode)
      MODE_RISE: count_evt = rise_evt;
      MODE_FALL: count_evt = fall_evt;
      MODE_BOTH: count_evt = rise_evt | fall_evt;
      default:   count_evt = 1'b0;
    endcase
  end

  // Debounce: o_q follows sync_out only after DEB_CYCLES consecutive
  // mismatching edges; any matching edge restarts the count.
  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      deb    <= '0;
      o_q    <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      o_rise <= rise_evt;
      o_fall <= fall_evt;
      if (flip) begin
        o_q <= sync_out;
        deb <= '0;
      end else if (sync_out != o_q) begin
        deb <= deb + DEB_W'(1);
      end else begin
        deb <= '0;
      end
    end
  end

  // Saturating event counter; a clear drops any event on the same edge.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_cnt <= '0;
      o_ovf <= 1'b0;
    end else if (i_clr) begin
      o_cnt <= '0;
      o_ovf <= 1'b0;
    end else if (count_evt) begin
      if (&o_cnt) begin
        o_ovf <= 1'b1;
      end else begin
        o_cnt <= o_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_edge_event_counter.sv
// Self-checking bench for edge_event_counter. Two instances share all inputs:
// the default 8-bit counter and a 2-bit counter for saturation behaviour.
// A queue-based reference model tracks the expected outputs of both.
module tb_edge_event_counter;
  import edge_pkg::*;

  localparam int S = 2;
  localparam int D = 4;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       d    = 1'b0;
  logic       clr  = 1'b0;
  logic [1:0] mode = MODE_RISE;

  logic       q, rise, fall, ovf;
  logic [7:0] cnt;
  logic       q2, rise2, fall2, ovf2;
  logic [1:0] cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  edge_event_counter #(.SYNC_STAGES(S), .DEB_CYCLES(D), .CNT_W(8)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_d(d), .i_clr(clr), .i_mode(mode),
    .o_q(q), .o_rise(rise), .o_fall(fall), .o_cnt(cnt), .o_ovf(ovf)
  );

  edge_event_counter #(.SYNC_STAGES(S), .DEB_CYCLES(D), .CNT_W(2)) dut_s (
    .i_clk(clk), .i_rstn(rstn), .i_d(d), .i_clr(clr), .i_mode(mode),
    .o_q(q2), .o_rise(rise2), .o_fall(fall2), .o_cnt(cnt2), .o_ovf(ovf2)
  );

  // ---------------- reference model ----------------
  // sync_q: the last S samples of i_d (front = value visible to the filter).
  // seen  : the filter inputs observed since reset, last D kept; o_q flips
  //         when all D of them disagree with the current level.
  bit       sync_q[$];
  bit       seen[$];
  bit       m_q, m_rise, m_fall, m_ovf, m_ovf2;
  bit [7:0] m_cnt;
  bit [1:0] m_cnt2;

  logic [14:0] dut_v;
  logic [14:0] mdl_v;
  assign dut_v = {q, rise, fall, cnt, ovf, cnt2, ovf2};
  assign mdl_v = {m_q, m_rise, m_fall, m_cnt, m_ovf, m_cnt2, m_ovf2};

  always @(posedge clk) begin : model
    bit v, all_mis, sel;
    if (!rstn) begin
      sync_q.delete();
      for (int i = 0; i < S; i++) sync_q.push_back(1'b0);
      seen.delete();
      m_q = 0; m_rise = 0; m_fall = 0;
      m_cnt = 0; m_ovf = 0; m_cnt2 = 0; m_ovf2 = 0;
    end else begin
      v = sync_q.pop_front();
      sync_q.push_back(d);
      seen.push_back(v);
      if (seen.size() > D) void'(seen.pop_front());
      all_mis = (seen.size() == D);
      foreach (seen[i]) if (seen[i] == m_q) all_mis = 0;
      m_rise = all_mis && v;
      m_fall = all_mis && !v;
      if (all_mis) m_q = v;
      case (mode)
        MODE_RISE: sel = m_rise;
        MODE_FALL: sel = m_fall;
        MODE_BOTH: sel = m_rise || m_fall;
        default:   sel = 0;
      endcase
      if (clr) begin
        m_cnt = 0; m_ovf = 0; m_cnt2 = 0; m_ovf2 = 0;
      end else if (sel) begin
        if (m_cnt == 8'hFF) m_ovf = 1; else m_cnt = m_cnt + 8'd1;
        if (m_cnt2 == 2'b11) m_ovf2 = 1; else m_cnt2 = m_cnt2 + 2'd1;
      end
    end
  end

  // Advance one clock; outputs are read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 0; d = 1; clr = 0; mode = MODE_RISE;
    repeat (5) begin
      tick();
      n_checks++;
      if (dut_v !== 15'h0) begin
        n_fail++;
        $display("FAIL reset_hold: outputs=%h required=%h", dut_v, 15'h0);
      end
    end
    rstn = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if (rise !== (k == 6) || q !== (k >= 6) || cnt !== ((k >= 6) ? 8'd1 : 8'd0)) begin
        n_fail++;
        $display("FAIL reset_release edge %0d: q=%b rise=%b cnt=%0d required q=%b rise=%b cnt=%0d",
                 k, q, rise, cnt, k >= 6, k == 6, (k >= 6) ? 1 : 0);
      end
      n_checks++;
      if (dut_v !== mdl_v) begin
        n_fail++;
        $display("FAIL reset_model edge %0d: dut=%h model=%h", k, dut_v, mdl_v);
      end
    end
  endtask

  task automatic test_glitch();
    int r_at, f_at;
    d = 0;
    repeat (10) tick();
    n_checks++;
    if (q !== 1'b0 || cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL glitch_setup: q=%b cnt=%0d required q=0 cnt=1", q, cnt);
    end
    d = 1;
    repeat (3) tick();
    d = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_checks++;
      if (q !== 1'b0 || rise !== 1'b0 || fall !== 1'b0 || cnt !== 8'd1) begin
        n_fail++;
        $display("FAIL glitch_reject cyc %0d: q=%b rise=%b fall=%b cnt=%0d required 0 0 0 1",
                 k, q, rise, fall, cnt);
      end
    end
    r_at = -1; f_at = -1;
    d = 1;
    for (int k = 0; k < 20; k++) begin
      if (k == 4) d = 0;
      tick();
      if (rise === 1'b1) r_at = k;
      if (fall === 1'b1) f_at = k;
      n_checks++;
      if (dut_v !== mdl_v) begin
        n_fail++;
        $display("FAIL glitch_model cyc %0d: dut=%h model=%h", k, dut_v, mdl_v);
      end
    end
    n_checks++;
    if (r_at != 5 || f_at != 9 || cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL glitch_min_pulse: rise_at=%0d fall_at=%0d cnt=%0d required 5 9 2",
               r_at, f_at, cnt);
    end
  endtask

  task automatic test_mode_both();
    int nr, nf;
    for (int pass = 0; pass < 2; pass++) begin
      clr = 1;
      tick();
      clr = 0;
      n_checks++;
      if (cnt !== 8'd0 || ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL mode_clear pass %0d: cnt=%0d ovf=%b required 0 0", pass, cnt, ovf);
      end
      mode = (pass == 0) ? MODE_BOTH : MODE_NONE;
      nr = 0; nf = 0;
      for (int k = 0; k < 60; k++) begin
        d = ((k % 20) < 10);
        tick();
        nr += int'(rise);
        nf += int'(fall);
        n_checks++;
        if (dut_v !== mdl_v) begin
          n_fail++;
          $display("FAIL mode_model pass %0d cyc %0d: dut=%h model=%h", pass, k, dut_v, mdl_v);
        end
      end
      n_checks++;
      if (nr != 3 || nf != 3 || cnt !== ((pass == 0) ? 8'd6 : 8'd0)) begin
        n_fail++;
        $display("FAIL mode_totals pass %0d: rises=%0d falls=%0d cnt=%0d required 3 3 %0d",
                 pass, nr, nf, cnt, (pass == 0) ? 6 : 0);
      end
    end
  endtask

  task automatic test_saturation();
    clr = 1;
    tick();
    clr = 0;
    mode = MODE_RISE;
    for (int i = 1; i <= 5; i++) begin
      for (int k = 0; k < 20; k++) begin
        d = (k < 10);
        tick();
      end
      n_checks++;
      if (cnt2 !== ((i < 3) ? 2'(i) : 2'd3) || ovf2 !== (i >= 4)) begin
        n_fail++;
        $display("FAIL saturation rise %0d: cnt=%0d ovf=%b required cnt=%0d ovf=%b",
                 i, cnt2, ovf2, (i < 3) ? i : 3, i >= 4);
      end
    end
    clr = 1;
    tick();
    clr = 0;
    n_checks++;
    if (cnt2 !== 2'd0 || ovf2 !== 1'b0) begin
      n_fail++;
      $display("FAIL saturation_clear: cnt=%0d ovf=%b required 0 0", cnt2, ovf2);
    end
  endtask

  task automatic test_clr_collision();
    mode = MODE_RISE;
    for (int k = 0; k < 80; k++) begin
      d = ((k % 20) < 10);
      tick();
    end
    n_checks++;
    if (ovf2 !== 1'b1 || cnt2 !== 2'd3 || cnt !== 8'd4) begin
      n_fail++;
      $display("FAIL collision_setup: ovf2=%b cnt2=%0d cnt=%0d required 1 3 4", ovf2, cnt2, cnt);
    end
    d = 1;
    repeat (5) tick();
    clr = 1;
    tick();
    clr = 0;
    n_checks++;
    if (rise !== 1'b1 || cnt !== 8'd0 || ovf !== 1'b0 || cnt2 !== 2'd0 || ovf2 !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_edge: rise=%b cnt=%0d ovf=%b cnt2=%0d ovf2=%b required 1 0 0 0 0",
               rise, cnt, ovf, cnt2, ovf2);
    end
    tick();
    n_checks++;
    if (rise !== 1'b0 || q !== 1'b1 || cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL collision_after: rise=%b q=%b cnt=%0d required 0 1 0", rise, q, cnt);
    end
  endtask

  task automatic test_reset_mid_debounce();
    d = 0;
    repeat (10) tick();
    d = 1;
    repeat (4) tick();
    rstn = 0;
    tick();
    rstn = 1;
    n_checks++;
    if (dut_v !== 15'h0) begin
      n_fail++;
      $display("FAIL mid_reset: outputs=%h required=%h", dut_v, 15'h0);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if (q !== (k >= 6) || rise !== (k == 6)) begin
        n_fail++;
        $display("FAIL mid_reset_release edge %0d: q=%b rise=%b required q=%b rise=%b",
                 k, q, rise, k >= 6, k == 6);
      end
    end
    // A reset pulse entirely between two edges must be invisible.
    d = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 2) begin
        rstn = 0;
        #2;
        rstn = 1;
      end
      n_checks++;
      if (q !== (k < 6) || fall !== (k == 6) || dut_v !== mdl_v) begin
        n_fail++;
        $display("FAIL rstn_between_edges edge %0d: q=%b fall=%b dut=%h required q=%b fall=%b model=%h",
                 k, q, fall, dut_v, k < 6, k == 6, mdl_v);
      end
    end
    n_checks++;
    if (cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL rstn_between_cnt: cnt=%0d required 1", cnt);
    end
  endtask

  task automatic test_random();
    int run;
    run = 0;
    for (int k = 0; k < 3000; k++) begin
      if (run == 0) begin
        d   = ~d;
        run = $urandom_range(1, 8);
      end
      run--;
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 39) == 0);
      tick();
      n_checks++;
      if (dut_v !== mdl_v || (rise && fall)) begin
        n_fail++;
        $display("FAIL random cyc %0d: dut=%h model=%h", k, dut_v, mdl_v);
      end
    end
    clr = 0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_mode_both();
    test_saturation();
    test_clr_collision();
    test_reset_mid_debounce();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
